// File: rtl/config_loader.sv
// Write-side sequencer for a config latch bank: takes config words over a
// valid/ready handshake and drives a registered data bus plus one-hot,
// registered per-word latch enables, with data stable one cycle before,
// during and one cycle after every enable pulse.
module config_loader #(
    parameter int WORD_W    = 32,
    parameter int NUM_WORDS = 12,
    parameter int IDX_W     = (NUM_WORDS > 1) ? $clog2(NUM_WORDS) : 1
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 io_start,
    input  logic                 io_abort,
    input  logic                 io_in_valid,
    output logic                 io_in_ready,
    input  logic [WORD_W-1:0]    io_in_data,
    output logic [WORD_W-1:0]    io_d_out,
    output logic [NUM_WORDS-1:0] io_configs_en,
    output logic                 io_busy,
    output logic                 io_done,
    output logic [IDX_W-1:0]     io_word_idx
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_WAIT,
        S_SETUP,
        S_STROBE,
        S_HOLD,
        S_DONE
    } state_e;

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_WORDS - 1);

    state_e                state_q, state_d;
    logic                  ready_q, ready_d;
    logic [WORD_W-1:0]     d_out_q, d_out_d;
    logic [NUM_WORDS-1:0]  en_q, en_d;
    logic                  busy_q, busy_d;
    logic                  done_q, done_d;
    logic [IDX_W-1:0]      idx_q, idx_d;

    // Next-state and next-output computation; every output is the registered
    // value for the state being entered, so enables never decode inputs directly.
    always_comb begin
        state_d = state_q;
        ready_d = ready_q;
        d_out_d = d_out_q;
        en_d    = '0;
        busy_d  = busy_q;
        done_d  = 1'b0;
        idx_d   = idx_q;

        case (state_q)
            S_IDLE: begin
                if (io_start && !io_abort) begin
                    state_d = S_WAIT;
                    ready_d = 1'b1;
                    busy_d  = 1'b1;
                    idx_d   = '0;
                end
            end
            S_WAIT: begin
                if (io_in_valid && ready_q) begin
                    d_out_d = io_in_data;
                    ready_d = 1'b0;
                    state_d = S_SETUP;
                end
            end
            S_SETUP: begin
                state_d = S_STROBE;
                en_d    = NUM_WORDS'(1) << idx_q;
            end
            S_STROBE: begin
                state_d = S_HOLD;
            end
            S_HOLD: begin
                if (idx_q == LAST_IDX) begin
                    state_d = S_DONE;
                    done_d  = 1'b1;
                end else begin
                    idx_d   = idx_q + IDX_W'(1);
                    state_d = S_WAIT;
                    ready_d = 1'b1;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
                busy_d  = 1'b0;
                idx_d   = '0;
            end
            default: begin
                state_d = S_IDLE;
                ready_d = 1'b0;
                busy_d  = 1'b0;
                idx_d   = '0;
            end
        endcase

        // Abort overrides everything outside IDLE; the data bus keeps its value.
        if (io_abort && (state_q != S_IDLE)) begin
            state_d = S_IDLE;
            ready_d = 1'b0;
            d_out_d = d_out_q;
            en_d    = '0;
            busy_d  = 1'b0;
            done_d  = 1'b0;
            idx_d   = '0;
        end
    end

    // State and output registers; async reset clears the enables immediately.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= S_IDLE;
            ready_q <= 1'b0;
            d_out_q <= '0;
            en_q    <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            idx_q   <= '0;
        end else begin
            state_q <= state_d;
            ready_q <= ready_d;
            d_out_q <= d_out_d;
            en_q    <= en_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            idx_q   <= idx_d;
        end
    end

    assign io_in_ready   = ready_q;
    assign io_d_out      = d_out_q;
    assign io_configs_en = en_q;
    assign io_busy       = busy_q;
    assign io_done       = done_q;
    assign io_word_idx   = idx_q;

endmodule

// File: tb/tb_config_loader.sv
// Scoreboard bench for config_loader: the stimulus pushes expected latch
// writes and done pulses into queues; a negedge monitor pops and compares
// whenever the DUT raises an enable or done.
module tb_config_loader;

    logic        clk = 1'b0;
    logic        reset;
    logic        io_start, io_abort, io_in_valid;
    logic [31:0] io_in_data;
    logic        io_in_ready;
    logic [31:0] io_d_out;
    logic [11:0] io_configs_en;
    logic        io_busy, io_done;
    logic [3:0]  io_word_idx;

    logic        s2_start, s2_abort, s2_valid;
    logic [7:0]  s2_data;
    logic        s2_ready;
    logic [7:0]  s2_d_out;
    logic [0:0]  s2_en;
    logic        s2_busy, s2_done;
    logic [0:0]  s2_idx;

    always #5 clk = ~clk;

    config_loader dut (
        .clk(clk), .reset(reset), .io_start(io_start), .io_abort(io_abort),
        .io_in_valid(io_in_valid), .io_in_ready(io_in_ready), .io_in_data(io_in_data),
        .io_d_out(io_d_out), .io_configs_en(io_configs_en), .io_busy(io_busy),
        .io_done(io_done), .io_word_idx(io_word_idx)
    );

    config_loader #(.WORD_W(8), .NUM_WORDS(1)) dut1 (
        .clk(clk), .reset(reset), .io_start(s2_start), .io_abort(s2_abort),
        .io_in_valid(s2_valid), .io_in_ready(s2_ready), .io_in_data(s2_data),
        .io_d_out(s2_d_out), .io_configs_en(s2_en), .io_busy(s2_busy),
        .io_done(s2_done), .io_word_idx(s2_idx)
    );

    typedef struct {
        logic [11:0] en;
        logic [31:0] data;
        int          acc;
    } exp_t;

    exp_t        exp_q[$];
    int          done_q[$];
    int          n_cmp = 0;
    int          n_err = 0;
    int          cyc   = 0;
    int          last_done_cyc = -1;
    logic [31:0] bank [12];

    always @(posedge clk) cyc <= cyc + 1;

    function automatic void check(string name, logic [63:0] act, logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (cyc %0d)", name, act, exp, cyc);
        end
    endfunction

    // Monitor: compares every enable pulse and done pulse against the queues.
    logic [11:0] prev_en = '0;
    logic [31:0] prev_d  = '0;
    logic        chk_after = 1'b0;
    logic [31:0] after_data = '0;
    always @(negedge clk) begin
        if (!reset) begin
            chk_after = 1'b0;
            prev_en   = '0;
        end else begin
            if (chk_after) begin
                check("data_hold_after_en", {32'd0, io_d_out}, {32'd0, after_data});
                check("en_low_after_pulse", {52'd0, io_configs_en}, 64'd0);
                chk_after = 1'b0;
            end
            if (io_configs_en != '0) begin
                check("en_onehot", {63'd0, $onehot(io_configs_en)}, 64'd1);
                if (prev_en != '0) check("en_back_to_back", {52'd0, prev_en}, 64'd0);
                if (exp_q.size() == 0) begin
                    check("unexpected_en", {52'd0, io_configs_en}, 64'd0);
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    check("en_value", {52'd0, io_configs_en}, {52'd0, e.en});
                    check("data_during_en", {32'd0, io_d_out}, {32'd0, e.data});
                    check("data_setup_before_en", {32'd0, prev_d}, {32'd0, e.data});
                    check("en_timing", 64'(cyc), 64'(e.acc + 1));
                    for (int i = 0; i < 12; i++)
                        if (io_configs_en[i]) bank[i] = io_d_out;
                    chk_after  = 1'b1;
                    after_data = e.data;
                end
            end
            if (io_done) begin
                last_done_cyc = cyc;
                if (done_q.size() == 0) check("unexpected_done", 64'd1, 64'd0);
                else check("done_timing", 64'(cyc), 64'(done_q.pop_front()));
            end
            prev_en = io_configs_en;
            prev_d  = io_d_out;
        end
    end

    // Offer one word; expectation is pushed when the accepting edge is next.
    task automatic send_word(int k, logic [31:0] d, bit last, output int acc);
        int n = 0;
        @(negedge clk);
        io_in_valid = 1'b1;
        io_in_data  = d;
        while (!io_in_ready && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (n >= 200) check("ready_timeout", 64'd0, 64'd1);
        acc = cyc + 1;
        exp_q.push_back('{en: 12'(1) << k, data: d, acc: acc});
        if (last) done_q.push_back(acc + 3);
        @(negedge clk);
        io_in_valid = 1'b0;
        io_in_data  = $urandom;
    endtask

    task automatic check_idle(string tag);
        check({tag, "_busy"}, {63'd0, io_busy}, 64'd0);
        check({tag, "_ready"}, {63'd0, io_in_ready}, 64'd0);
        check({tag, "_en"}, {52'd0, io_configs_en}, 64'd0);
        check({tag, "_done"}, {63'd0, io_done}, 64'd0);
        check({tag, "_idx"}, {60'd0, io_word_idx}, 64'd0);
    endtask

    task automatic run_load(logic [31:0] base, int gap_idx, int glitch_idx,
                            int abort_idx, int reset_idx);
        int acc, first_acc, n;
        @(negedge clk) io_start = 1'b1;
        @(negedge clk) io_start = 1'b0;
        check("busy_after_start", {63'd0, io_busy}, 64'd1);
        for (int k = 0; k < 12; k++) begin
            if (k == gap_idx) begin
                n = 0;
                while (!io_in_ready && n < 50) begin @(negedge clk); n++; end
                for (int g = 0; g < 5; g++) begin
                    check("gap_ready", {63'd0, io_in_ready}, 64'd1);
                    check("gap_en", {52'd0, io_configs_en}, 64'd0);
                    check("gap_idx", {60'd0, io_word_idx}, 64'(k));
                    @(negedge clk);
                end
            end
            send_word(k, base + 32'(k), k == 11, acc);
            if (k == 0) first_acc = acc;
            check("word_idx", {60'd0, io_word_idx}, 64'(k));
            if (k == glitch_idx) begin
                io_start = 1'b1;
                @(negedge clk) io_start = 1'b0;
            end
            if (k == abort_idx) begin
                @(negedge clk);
                @(negedge clk) io_abort = 1'b1;
                @(negedge clk) io_abort = 1'b0;
                check_idle("abort");
                repeat (6) @(negedge clk);
                return;
            end
            if (k == reset_idx) begin
                @(negedge clk);
                #1 check("en_before_reset", {52'd0, io_configs_en}, 64'h004);
                #1 reset = 1'b0;
                #1 check_idle("reset_async");
                check("reset_async_dout", {32'd0, io_d_out}, 64'd0);
                @(negedge clk);
                #2 reset = 1'b1;
                @(negedge clk);
                check_idle("after_reset");
                check("after_reset_dout", {32'd0, io_d_out}, 64'd0);
                return;
            end
        end
        n = 0;
        while (!io_done && n < 50) begin @(negedge clk); n++; end
        check("done_seen", {63'd0, io_done}, 64'd1);
        check("busy_in_done", {63'd0, io_busy}, 64'd1);
        if (gap_idx < 0) check("full_load_latency", 64'(cyc), 64'(first_acc + 47));
        @(negedge clk);
        check_idle("post_done");
        check("dout_kept", {32'd0, io_d_out}, {32'd0, base + 32'd11});
    endtask

    task automatic check_bank(logic [31:0] base, int upto, logic [31:0] base_hi);
        for (int k = 0; k < 12; k++)
            check("bank_word", {32'd0, bank[k]},
                  {32'd0, (k <= upto) ? base + 32'(k) : base_hi + 32'(k)});
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int acc;
        reset = 1'b0; io_start = 1'b0; io_abort = 1'b0;
        io_in_valid = 1'b0; io_in_data = '0;
        s2_start = 1'b0; s2_abort = 1'b0; s2_valid = 1'b0; s2_data = '0;
        for (int i = 0; i < 12; i++) bank[i] = '0;
        repeat (3) @(negedge clk);
        check_idle("reset");
        check("reset_dout", {32'd0, io_d_out}, 64'd0);
        #2 reset = 1'b1;
        @(negedge clk);
        check_idle("idle_after_release");

        // Plain full load, always-valid source.
        run_load(32'hA000_0000, -1, -1, -1, -1);
        check_bank(32'hA000_0000, 11, 32'h0);

        // Gap before word 3, stray start at word 4.
        run_load(32'hB000_0000, 3, 4, -1, -1);
        check_bank(32'hB000_0000, 11, 32'h0);

        // Abort in HOLD of word 6, then a clean reload.
        run_load(32'hC000_0000, -1, -1, 6, -1);
        check_bank(32'hC000_0000, 6, 32'hB000_0000);
        run_load(32'hD000_0000, -1, -1, -1, -1);
        check_bank(32'hD000_0000, 11, 32'h0);

        // Start and abort together in IDLE.
        @(negedge clk) begin io_start = 1'b1; io_abort = 1'b1; end
        @(negedge clk) begin io_start = 1'b0; io_abort = 1'b0; end
        check_idle("start_abort_idle");
        @(negedge clk);
        check_idle("start_abort_idle2");

        // Async reset during the enable pulse of word 2.
        run_load(32'hE000_0000, -1, -1, -1, 2);

        // Single-word, 8-bit instance.
        @(negedge clk) s2_start = 1'b1;
        @(negedge clk) begin
            s2_start = 1'b0; s2_valid = 1'b1; s2_data = 8'h5A;
        end
        check("sweep_ready", {63'd0, s2_ready}, 64'd1);
        acc = cyc + 1;
        @(negedge clk) begin s2_valid = 1'b0; s2_data = 8'h00; end
        for (int i = 0; i < 5; i++) begin
            check("sweep_cycle", 64'(cyc), 64'(acc + i));
            check("sweep_en", {63'd0, s2_en}, (i == 1) ? 64'd1 : 64'd0);
            check("sweep_done", {63'd0, s2_done}, (i == 3) ? 64'd1 : 64'd0);
            check("sweep_dout", {56'd0, s2_d_out}, 64'h5A);
            if (i == 4) check("sweep_busy_end", {63'd0, s2_busy}, 64'd0);
            @(negedge clk);
        end

        check("exp_queue_drained", 64'(exp_q.size()), 64'd0);
        check("done_queue_drained", 64'(done_q.size()), 64'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
